// File: rtl/cu_array_read_cmd_gen_if.sv
// Request / command / response bundle between CU job control, the read-command
// generator and the CU command arbiter. The slave modport is the generator's view.
interface cu_array_read_cmd_gen_if #(
  parameter int CACHELINE_SIZE = 128,
  parameter int ELEMENT_SIZE   = 4
);
  localparam int N     = CACHELINE_SIZE / ELEMENT_SIZE;
  localparam int IDX_W = $clog2(N);

  logic              req_valid;
  logic              req_ready;
  logic [63:0]       req_base_addr;
  logic [31:0]       req_count;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [63:0]       cmd_address;
  logic [7:0]        cmd_size;
  logic [IDX_W-1:0]  cmd_first_index;
  logic [IDX_W:0]    cmd_elem_count;
  logic [7:0]        cmd_tag;
  logic              cmd_last;
  logic              rsp_done;
  logic              done;
  logic              rsp_underflow;

  modport slave (
    input  req_valid, req_base_addr, req_count, cmd_ready, rsp_done,
    output req_ready, cmd_valid, cmd_address, cmd_size, cmd_first_index,
           cmd_elem_count, cmd_tag, cmd_last, done, rsp_underflow
  );

  modport master (
    output req_valid, req_base_addr, req_count, cmd_ready, rsp_done,
    input  req_ready, cmd_valid, cmd_address, cmd_size, cmd_first_index,
           cmd_elem_count, cmd_tag, cmd_last, done, rsp_underflow
  );
endinterface

// File: rtl/cu_array_read_cmd_gen.sv
// Splits one array-fetch request into cacheline-aligned read commands with a
// credit limit on outstanding commands. Half-line fetches: CU_HALF_LINE_FETCH_EN.
module cu_array_read_cmd_gen #(
  parameter int         CACHELINE_SIZE  = 128,
  parameter int         ELEMENT_SIZE    = 4,
  parameter int         ELEMS_PER_LINE  = CACHELINE_SIZE / ELEMENT_SIZE,
  parameter int         MAX_OUTSTANDING = 16,
  parameter logic [7:0] CMD_ID          = 8'd0
) (
  input logic                      clock,
  input logic                      reset,
  cu_array_read_cmd_gen_if.slave   io_bus
);
  localparam int N      = ELEMS_PER_LINE;
  localparam int IDX_W  = $clog2(N);
  localparam int LINE_W = $clog2(CACHELINE_SIZE);
  localparam int EL_W   = $clog2(ELEMENT_SIZE);
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [IDX_W:0]   N_L        = (IDX_W+1)'(N);
  localparam logic [63:0]      LINE_MASK  = ~64'(CACHELINE_SIZE - 1);
  localparam logic [63:0]      LINE_BYTES = 64'(CACHELINE_SIZE);
  localparam logic [7:0]       SIZE_FULL  = 8'(CACHELINE_SIZE);
  localparam logic [OUT_W-1:0] OUT_MAX    = OUT_W'(MAX_OUTSTANDING);
`ifdef CU_HALF_LINE_FETCH_EN
  localparam logic [63:0]      HALF_BYTES = 64'(CACHELINE_SIZE / 2);
  localparam logic [7:0]       SIZE_HALF  = 8'(CACHELINE_SIZE / 2);
  localparam logic [IDX_W-1:0] HALF_MASK  = IDX_W'(N / 2 - 1);
`endif

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]       r_state;
  logic             r_req_ready;
  logic             r_done;
  logic             r_underflow;
  logic [OUT_W-1:0] r_out;
  logic [63:0]      r_line_addr;
  logic [31:0]      r_remaining;
  logic             r_cmd_pending;
  logic [63:0]      r_cmd_address;
  logic [7:0]       r_cmd_size;
  logic [IDX_W-1:0] r_cmd_first;
  logic [IDX_W:0]   r_cmd_count;
  logic [7:0]       r_cmd_tag;
  logic             r_cmd_last;

  logic             w_accept;
  logic             w_cmd_valid;
  logic             w_hs;
  logic             w_load;
  logic [63:0]      w_src_line;
  logic [IDX_W-1:0] w_src_off;
  logic [31:0]      w_src_rem;
  logic [IDX_W:0]   w_room;
  logic [IDX_W:0]   w_cnt;
  logic             w_last;
  logic [63:0]      w_addr;
  logic [7:0]       w_size;
  logic [IDX_W-1:0] w_first;
  logic [OUT_W-1:0] w_out_next;
  logic             w_underflow_set;
  logic [1:0]       w_state_next;
  logic             w_done_next;
`ifdef CU_HALF_LINE_FETCH_EN
  logic [IDX_W-1:0] w_end;
`endif

  // Credit gate uses only the registered count, so a same-cycle response frees issue next cycle.
  assign w_cmd_valid = r_cmd_pending && (r_out != OUT_MAX);
  assign w_hs        = w_cmd_valid && io_bus.cmd_ready;
  assign w_accept    = r_req_ready && io_bus.req_valid;
  assign w_load      = (w_accept && (io_bus.req_count != 32'd0)) || (w_hs && !r_cmd_last);

  // Next command: from the new request on accept, else the following line of the current one.
  always_comb begin
    if (w_accept) begin
      w_src_line = io_bus.req_base_addr & LINE_MASK;
      w_src_off  = io_bus.req_base_addr[LINE_W-1:EL_W];
      w_src_rem  = io_bus.req_count;
    end else begin
      w_src_line = r_line_addr + LINE_BYTES;
      w_src_off  = '0;
      w_src_rem  = r_remaining - 32'(r_cmd_count);
    end
    w_room  = N_L - {1'b0, w_src_off};
    w_cnt   = (w_src_rem < 32'(w_room)) ? w_src_rem[IDX_W:0] : w_room;
    w_last  = (32'(w_cnt) == w_src_rem);
    w_addr  = w_src_line;
    w_size  = SIZE_FULL;
    w_first = w_src_off;
`ifdef CU_HALF_LINE_FETCH_EN
    w_end = w_src_off + w_cnt[IDX_W-1:0] - IDX_W'(1);
    if (w_src_off[IDX_W-1] == w_end[IDX_W-1]) begin
      w_size  = SIZE_HALF;
      w_addr  = w_src_line + (w_src_off[IDX_W-1] ? HALF_BYTES : 64'd0);
      w_first = w_src_off & HALF_MASK;
    end
`endif
  end

  always_comb begin
    w_out_next      = r_out;
    w_underflow_set = 1'b0;
    if (w_hs && !io_bus.rsp_done) begin
      w_out_next = r_out + OUT_W'(1);
    end else if (!w_hs && io_bus.rsp_done) begin
      if (r_out == '0) w_underflow_set = 1'b1;
      else             w_out_next      = r_out - OUT_W'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_next = (io_bus.req_count == 32'd0) ? ST_DRAIN : ST_ISSUE;
      ST_ISSUE: if (w_hs && r_cmd_last) w_state_next = ST_DRAIN;
      ST_DRAIN: if (w_out_next == '0) begin
        w_done_next  = 1'b1;
        w_state_next = ST_IDLE;
      end
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_req_ready   <= 1'b0;
      r_done        <= 1'b0;
      r_underflow   <= 1'b0;
      r_out         <= '0;
      r_line_addr   <= '0;
      r_remaining   <= '0;
      r_cmd_pending <= 1'b0;
      r_cmd_address <= '0;
      r_cmd_size    <= '0;
      r_cmd_first   <= '0;
      r_cmd_count   <= '0;
      r_cmd_tag     <= '0;
      r_cmd_last    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_req_ready <= (w_state_next == ST_IDLE) && !w_done_next;
      r_done      <= w_done_next;
      r_out       <= w_out_next;
      if (w_underflow_set) r_underflow <= 1'b1;
      if (w_load) begin
        r_cmd_pending <= 1'b1;
        r_line_addr   <= w_src_line;
        r_remaining   <= w_src_rem;
        r_cmd_address <= w_addr;
        r_cmd_size    <= w_size;
        r_cmd_first   <= w_first;
        r_cmd_count   <= w_cnt;
        r_cmd_tag     <= CMD_ID;
        r_cmd_last    <= w_last;
      end else if (w_hs) begin
        r_cmd_pending <= 1'b0;
      end
    end
  end

  assign io_bus.req_ready       = r_req_ready;
  assign io_bus.cmd_valid       = w_cmd_valid;
  assign io_bus.cmd_address     = r_cmd_address;
  assign io_bus.cmd_size        = r_cmd_size;
  assign io_bus.cmd_first_index = r_cmd_first;
  assign io_bus.cmd_elem_count  = r_cmd_count;
  assign io_bus.cmd_tag         = r_cmd_tag;
  assign io_bus.cmd_last        = r_cmd_last;
  assign io_bus.done            = r_done;
  assign io_bus.rsp_underflow   = r_underflow;
endmodule

// File: tb/tb_cu_array_read_cmd_gen.sv
// Directed bench for cu_array_read_cmd_gen (MAX_OUTSTANDING=2, CMD_ID=0x5A);
// expectations follow CU_HALF_LINE_FETCH_EN when it is defined.
module tb_cu_array_read_cmd_gen;
  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;

  cu_array_read_cmd_gen_if #(.CACHELINE_SIZE(128), .ELEMENT_SIZE(4)) bus ();

  cu_array_read_cmd_gen #(
    .CACHELINE_SIZE (128),
    .ELEMENT_SIZE   (4),
    .MAX_OUTSTANDING(2),
    .CMD_ID         (8'h5A)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .io_bus (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_req(input logic [63:0] base, input logic [31:0] count);
    bus.req_valid     = 1'b1;
    bus.req_base_addr = base;
    bus.req_count     = count;
    tick();
    bus.req_valid = 1'b0;
    $display("[TB] req base=0x%0h count=%0d", base, count);
  endtask

  task automatic check_cmd(input string tag, input logic [63:0] addr, input logic [7:0] size,
                           input logic [4:0] first, input logic [5:0] cnt, input logic last);
    $display("[TB] cmd %s addr=0x%0h size=%0d first=%0d count=%0d last=%0d", tag,
             bus.cmd_address, bus.cmd_size, bus.cmd_first_index, bus.cmd_elem_count, bus.cmd_last);
    check({tag, ".valid"}, bus.cmd_valid, 1'b1);
    check({tag, ".addr"},  bus.cmd_address, addr);
    check({tag, ".size"},  bus.cmd_size, size);
    check({tag, ".first"}, bus.cmd_first_index, first);
    check({tag, ".count"}, bus.cmd_elem_count, cnt);
    check({tag, ".last"},  bus.cmd_last, last);
  endtask

  initial begin
    int done_pulses;
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_base_addr = '0;
    bus.req_count = '0;
    bus.cmd_ready = 1'b0;
    bus.rsp_done = 1'b0;

    // Reset state
    tick();
    check("rst.req_ready", bus.req_ready, 1'b0);
    check("rst.cmd_valid", bus.cmd_valid, 1'b0);
    check("rst.done", bus.done, 1'b0);
    check("rst.underflow", bus.rsp_underflow, 1'b0);
    check("rst.cmd_last", bus.cmd_last, 1'b0);
    check("rst.cmd_addr", bus.cmd_address, 64'd0);
    check("rst.cmd_tag", bus.cmd_tag, 8'd0);
    reset = 1'b0;
    tick();
    check("idle.req_ready", bus.req_ready, 1'b1);
    done_pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.done) done_pulses++;
    end
    check("idle.no_done", done_pulses, 0);
    check("idle.cmd_valid", bus.cmd_valid, 1'b0);

    // Unaligned start spanning two lines, first command held under back-pressure
    send_req(64'h1008, 32'd40);
    check("r1.req_ready_busy", bus.req_ready, 1'b0);
    check_cmd("r1.c0", 64'h1000, 8'd128, 5'd2, 6'd30, 1'b0);
    check("r1.c0.tag", bus.cmd_tag, 8'h5A);
    tick();
    check_cmd("r1.c0.hold", 64'h1000, 8'd128, 5'd2, 6'd30, 1'b0);
    bus.cmd_ready = 1'b1;
    tick();
`ifdef CU_HALF_LINE_FETCH_EN
    check_cmd("r1.c1", 64'h1080, 8'd64, 5'd0, 6'd10, 1'b1);
`else
    check_cmd("r1.c1", 64'h1080, 8'd128, 5'd0, 6'd10, 1'b1);
`endif
    tick();
    bus.cmd_ready = 1'b0;
    check("r1.valid_after_last", bus.cmd_valid, 1'b0);
    bus.rsp_done = 1'b1;
    tick();
    check("r1.done_early", bus.done, 1'b0);
    tick();
    bus.rsp_done = 1'b0;
    check("r1.done", bus.done, 1'b1);
    check("r1.ready_during_done", bus.req_ready, 1'b0);
    tick();
    check("r1.done_pulse_end", bus.done, 1'b0);
    check("r1.ready_after_done", bus.req_ready, 1'b1);

    // Short run inside the upper half of a line
    bus.cmd_ready = 1'b1;
    send_req(64'h1048, 32'd4);
`ifdef CU_HALF_LINE_FETCH_EN
    check_cmd("r2.c0", 64'h1040, 8'd64, 5'd2, 6'd4, 1'b1);
`else
    check_cmd("r2.c0", 64'h1000, 8'd128, 5'd18, 6'd4, 1'b1);
`endif
    tick();
    bus.rsp_done = 1'b1;
    tick();
    bus.rsp_done = 1'b0;
    check("r2.done", bus.done, 1'b1);
    tick();

    // Credit limit of 2 over a five-line request
    send_req(64'h2000, 32'd160);
    check_cmd("r3.c0", 64'h2000, 8'd128, 5'd0, 6'd32, 1'b0);
    tick();
    check_cmd("r3.c1", 64'h2080, 8'd128, 5'd0, 6'd32, 1'b0);
    tick();
    check("r3.blocked", bus.cmd_valid, 1'b0);
    check("r3.blocked_addr", bus.cmd_address, 64'h2100);
    tick();
    tick();
    tick();
    check("r3.still_blocked", bus.cmd_valid, 1'b0);
    bus.rsp_done = 1'b1;
    tick();
    check_cmd("r3.c2", 64'h2100, 8'd128, 5'd0, 6'd32, 1'b0);
    tick();
    bus.rsp_done = 1'b0;
    check_cmd("r3.c3_after_simul", 64'h2180, 8'd128, 5'd0, 6'd32, 1'b0);
    tick();
    check("r3.blocked2", bus.cmd_valid, 1'b0);
    check("r3.c4_last_held", bus.cmd_last, 1'b1);
    bus.rsp_done = 1'b1;
    tick();
    bus.rsp_done = 1'b0;
    check_cmd("r3.c4", 64'h2200, 8'd128, 5'd0, 6'd32, 1'b1);
    tick();
    check("r3.valid_after_last", bus.cmd_valid, 1'b0);
    bus.rsp_done = 1'b1;
    tick();
    check("r3.done_early", bus.done, 1'b0);
    tick();
    bus.rsp_done = 1'b0;
    check("r3.done", bus.done, 1'b1);
    check("r3.no_underflow", bus.rsp_underflow, 1'b0);
    tick();

    // Zero-length request, then a stray response
    send_req(64'h4000, 32'd0);
    check("r4.no_cmd", bus.cmd_valid, 1'b0);
    check("r4.done_not_yet", bus.done, 1'b0);
    tick();
    check("r4.done", bus.done, 1'b1);
    tick();
    check("r4.done_end", bus.done, 1'b0);
    bus.rsp_done = 1'b1;
    tick();
    bus.rsp_done = 1'b0;
    $display("[TB] stray rsp_done while idle");
    check("r4.underflow", bus.rsp_underflow, 1'b1);
    tick();
    tick();
    check("r4.underflow_sticky", bus.rsp_underflow, 1'b1);

    // Reset abandons a request; a late response flags underflow
    send_req(64'h3000, 32'd100);
    tick();
    reset = 1'b1;
    tick();
    check("r5.rst_cmd_valid", bus.cmd_valid, 1'b0);
    check("r5.rst_underflow", bus.rsp_underflow, 1'b0);
    check("r5.rst_req_ready", bus.req_ready, 1'b0);
    reset = 1'b0;
    tick();
    check("r5.req_ready", bus.req_ready, 1'b1);
    check("r5.cmd_valid", bus.cmd_valid, 1'b0);
    bus.rsp_done = 1'b1;
    tick();
    bus.rsp_done = 1'b0;
    $display("[TB] late rsp_done after reset");
    check("r5.late_underflow", bus.rsp_underflow, 1'b1);
    check("r5.no_done", bus.done, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
